uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Serial-to-parallel UART receiver; the downstream peer of the UART transmitter on the same link.
//  Recovers 8N1/8E1/8N2/8E2 frames (LSB first, even parity) from rx_i using an oversampling clock.
//  Delivers bytes on a valid/ready handshake with per-byte parity/framing flags and an overrun pulse.
// PARAMETERS
//  OVERSAMPLE  16  clk_i cycles per bit period; even, >=4. Bit counter width = $clog2(OVERSAMPLE).
// PORTS
//  arst_ni        in   1  asynchronous active-low reset
//  clk_i          in   1  clock, OVERSAMPLE x baud rate
//  rx_i           in   1  serial line, asynchronous, idles high
//  parity_en_i    in   1  1 = even parity bit expected after data bit 7
//  extra_stop_i   in   1  1 = two stop bits expected
//  data_o         out  8  received byte
//  data_valid_o   out  1  data_o and flags valid; held until accepted
//  data_ready_i   in   1  consumer accepts when data_valid_o && data_ready_i
//  parity_err_o   out  1  parity mismatch for byte on data_o; qualified by data_valid_o
//  frame_err_o    out  1  a stop bit sampled 0 for byte on data_o; qualified by data_valid_o
//  overrun_o      out  1  1-cycle pulse: completed frame dropped, output register still full
// BEHAVIOUR
//  Reset: all outputs 0, synchroniser flops 1, FSM IDLE, counters 0. Reset mid-frame aborts the frame silently.
//  rx_i passes a 2-flop synchroniser; "rx" below is the synchronised value (2-cycle input latency).
//  States (uart_rx_state_e): IDLE, START, DATA, PARITY, STOP, EXTRA_STOP.
//  IDLE: arm on falling edge only (previous rx=1, current rx=0); a held-low line never re-arms.
//   On the edge: cnt<=0, latch parity_en_i/extra_stop_i into frame config, go START.
//   Config inputs changed mid-frame take effect at the next frame.
//  Sample point: cnt == OVERSAMPLE/2-1 in START; cnt == OVERSAMPLE-1 in every later state (bit centre).
//   cnt wraps to 0 on each sample point.
//  START: sample 1 -> false start, back to IDLE, nothing reported. Sample 0 -> DATA, bit_idx<=0.
//  DATA: shift sample into bit 7 of shift reg (LSB first); after bit_idx 7 -> PARITY if parity enabled, else STOP.
//  PARITY: perr <= sample ^ (^shift); go STOP.
//  STOP: ferr <= ~sample. extra_stop enabled -> EXTRA_STOP; else frame complete, go IDLE.
//  EXTRA_STOP: ferr <= ferr | ~sample; frame complete, go IDLE.
//   Returning at the mid-stop point leaves a half-bit margin for the next start edge.
//  Frame complete (cycle C):
//   - output empty, or data_ready_i=1 in C: data_o/parity_err_o/frame_err_o load; data_valid_o=1 from C+1.
//   - data_valid_o=1 and data_ready_i=0 in C: new frame dropped, outputs unchanged, overrun_o=1 in C+1 only.
//  Frames with framing/parity errors are still delivered, with the flags set. perr=0 when parity disabled.
//  Break (rx low for full frame): delivers 0x00 with frame_err_o=1, then waits in IDLE for a fresh falling edge.
//  data_valid_o drops the cycle after acceptance unless a new frame loads in the same cycle.
// CONFIGURATION
//  UART_RX_MAJORITY_VOTE_EN defined: every sample = majority of rx at cnt = centre-1, centre, centre+1.
//   Decision is registered at centre+1, so each state transition is one cycle later; counter period unchanged.
//  Undefined: single sample of rx at the centre cycle; no vote logic instantiated.
// STRUCTURE
//  uart_rx_pkg: uart_rx_state_e, UART_RX_DATA_W = 8.
//  Sub-module uart_rx_fsm: state, cnt, bit_idx; outputs sample strobe and current state.
//  Top level owns: synchroniser, vote, shift reg, perr/ferr, output register, handshake.
// TESTING (OVERSAMPLE=16, bit = 16 clk)
//  0xA5, parity off, 1 stop, ready=1 -> data_o=0xA5, valid 1 cycle, parity_err_o=0, frame_err_o=0.
//  0x3C, parity on, parity bit sent as 1 (correct is 0) -> data_o=0x3C, parity_err_o=1.
//   Same with parity bit 0 -> parity_err_o=0.
//  0x81, extra_stop on, 2nd stop driven 0 -> data_o=0x81, frame_err_o=1.
//   Then rx held low for 20 bits -> one 0x00 with frame_err_o=1, no further frames.
//  rx low for 4 clk then high -> false start: no data_valid_o, FSM back in IDLE.
//  Frames 0x11 then 0x22 back-to-back, ready=0 -> data_o stays 0x11, overrun_o single pulse.
//   ready=1 -> 0x11 accepted, valid drops.
//  1-clk inverted glitch at centre of data bit 3 of 0x00:
//   - macro defined -> data_o=0x00.
//   - macro undefined -> data_o=0x08.
//  arst_ni low during DATA of a frame -> all outputs 0.
//   Next clean frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver slice.
package uart_rx_pkg;

  localparam int unsigned UART_RX_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    EXTRA_STOP
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte delivery channel: valid/ready handshake plus per-byte error flags.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic [UART_RX_DATA_W-1:0] data_o;
  logic                      data_valid_o;
  logic                      data_ready_i;
  logic                      parity_err_o;
  logic                      frame_err_o;
  logic                      overrun_o;

  modport master (
    output data_o, data_valid_o, parity_err_o, frame_err_o, overrun_o,
    input  data_ready_i
  );

  modport slave (
    input  data_o, data_valid_o, parity_err_o, frame_err_o, overrun_o,
    output data_ready_i
  );

endinterface

// File: rtl/uart_rx_fsm.sv
// Frame sequencer: tracks bit position and bit-centre timing, latches per-frame config.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic           clk_i,
  input  logic           arst_ni,
  input  logic           fall_i,
  input  logic           decide_i,
  input  logic           sample_i,
  input  logic           parity_en_i,
  input  logic           extra_stop_i,
  output uart_rx_state_e state_o,
  output logic           centre_o,
  output logic           done_o
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(UART_RX_DATA_W);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_RX_DATA_W - 1);

  uart_rx_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             par_en_q, par_en_d;
  logic             xstop_q, xstop_d;
  logic             at_centre;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      par_en_q  <= 1'b0;
      xstop_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      par_en_q  <= par_en_d;
      xstop_q   <= xstop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    par_en_d  = par_en_q;
    xstop_d   = xstop_q;
    // The counter wraps on the centre alone; the decision may land a cycle later.
    cnt_d     = at_centre ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (fall_i) begin
          state_d  = START;
          par_en_d = parity_en_i;
          xstop_d  = extra_stop_i;
        end
      end
      START: begin
        if (decide_i) begin
          state_d   = sample_i ? IDLE : DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (decide_i) begin
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == LAST_IDX) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (decide_i) state_d = STOP;
      end
      STOP: begin
        if (decide_i) state_d = xstop_q ? EXTRA_STOP : IDLE;
      end
      EXTRA_STOP: begin
        if (decide_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || state_d == IDLE) cnt_d = '0;
  end

  always_comb begin
    state_o   = state_q;
    at_centre = (state_q == START) ? (cnt_q == HALF_C) : (cnt_q == FULL_C);
    centre_o  = (state_q != IDLE) && at_centre;
    done_o    = decide_i && ((state_q == STOP && !xstop_q) || state_q == EXTRA_STOP);
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: synchroniser, bit sampling, shift register and output handshake.
// Optional UART_RX_MAJORITY_VOTE_EN: 3-sample majority around each bit centre.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic arst_ni,
  input  logic clk_i,
  input  logic rx_i,
  input  logic parity_en_i,
  input  logic extra_stop_i,
  uart_rx_if.master out_if
);

  logic                      sync1_q, sync1_d;
  logic                      sync2_q, sync2_d;
  logic                      rx_d1_q, rx_d1_d;
  logic [UART_RX_DATA_W-1:0] shift_q, shift_d;
  logic                      perr_q, perr_d;
  logic                      ferr_q, ferr_d;
  logic [UART_RX_DATA_W-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      perr_out_q, perr_out_d;
  logic                      ferr_out_q, ferr_out_d;
  logic                      overrun_q, overrun_d;

  logic           fall;
  logic           decide;
  logic           sample;
  logic           centre;
  logic           done;
  uart_rx_state_e state;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_d1_q    <= 1'b1;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      rx_d1_q    <= rx_d1_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic rx_d2_q, rx_d2_d;
  logic centre_q, centre_d;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rx_d2_q  <= 1'b1;
      centre_q <= 1'b0;
    end else begin
      rx_d2_q  <= rx_d2_d;
      centre_q <= centre_d;
    end
  end

  // One cycle after the centre, rx_d2/rx_d1/rx hold the centre-1/centre/centre+1 samples.
  always_comb begin
    rx_d2_d  = rx_d1_q;
    centre_d = centre;
    decide   = centre_q;
    sample   = (rx_d2_q & rx_d1_q) | (rx_d2_q & sync2_q) | (rx_d1_q & sync2_q);
  end
`else
  always_comb begin
    decide = centre;
    sample = sync2_q;
  end
`endif

  uart_rx_fsm #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_fsm (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .fall_i      (fall),
    .decide_i    (decide),
    .sample_i    (sample),
    .parity_en_i (parity_en_i),
    .extra_stop_i(extra_stop_i),
    .state_o     (state),
    .centre_o    (centre),
    .done_o      (done)
  );

  always_comb begin
    sync1_d    = rx_i;
    sync2_d    = sync1_q;
    rx_d1_d    = sync2_q;
    fall       = rx_d1_q & ~sync2_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    overrun_d  = 1'b0;

    if (state == IDLE && fall) begin
      perr_d = 1'b0;
      ferr_d = 1'b0;
    end

    if (decide) begin
      case (state)
        DATA:       shift_d = {sample, shift_q[UART_RX_DATA_W-1:1]};
        PARITY:     perr_d  = sample ^ (^shift_q);
        STOP:       ferr_d  = ~sample;
        EXTRA_STOP: ferr_d  = ferr_q | ~sample;
        default:    ;
      endcase
    end

    if (valid_q && out_if.data_ready_i) valid_d = 1'b0;

    // Final stop flag comes from ferr_d so the completing sample is included.
    if (done) begin
      if (!valid_q || out_if.data_ready_i) begin
        data_d     = shift_q;
        perr_out_d = perr_q;
        ferr_out_d = ferr_d;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    out_if.data_o       = data_q;
    out_if.data_valid_o = valid_q;
    out_if.parity_err_o = perr_out_q;
    out_if.frame_err_o  = ferr_out_q;
    out_if.overrun_o    = overrun_q;
  end

endmodule
